// File: rtl/rotate_left_seq_if.sv
// -----------------------------------------------------------------------------
// rotate_left_seq_if
//   Handshake/data bundle for the sequential left-rotate unit.
//   master : requester side (drives start, a, amt; observes ready, done_tick, y)
//   slave  : rotate unit side (observes start, a, amt; drives ready, done_tick, y)
// Signals
//   start     request, honoured only while ready=1
//   a         N-bit operand, captured on the accepted start edge
//   amt       W-bit rotate amount 0..N-1, captured with a
//   ready     unit is idle and can accept start
//   done_tick one-cycle pulse, y holds the finished result
//   y         registered result, held until the next accepted start
// -----------------------------------------------------------------------------
interface rotate_left_seq_if #(
    parameter int N = 8,
    parameter int W = 3
);
    logic         start;
    logic [N-1:0] a;
    logic [W-1:0] amt;
    logic         ready;
    logic         done_tick;
    logic [N-1:0] y;

    modport master (
        output start, a, amt,
        input  ready, done_tick, y
    );

    modport slave (
        input  start, a, amt,
        output ready, done_tick, y
    );
endinterface

// File: rtl/rotate_left_seq.sv
// -----------------------------------------------------------------------------
// rotate_left_seq
//   Sequential left rotator: captures an operand and an amount on an accepted
//   start, then rotates the operand left by one bit per clock until the amount
//   is used up, and signals completion with a one-cycle done_tick.
// Ports
//   clk   system clock, rising edge active
//   reset asynchronous, active-high reset; aborts any operation in progress
//   bus   rotate_left_seq_if.slave (start, a, amt, ready, done_tick, y)
// -----------------------------------------------------------------------------
module rotate_left_seq #(
    parameter int N = 8,
    parameter int W = 3
) (
    input  logic                clk,
    input  logic                reset,
    rotate_left_seq_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE,
        OP,
        DONE
    } state_t;

    state_t         r_state;
    state_t         w_nextState;
    logic [N-1:0]   r_data;
    logic [W-1:0]   r_cnt;
    logic           w_ready;
    logic           w_doneTick;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic. A zero amount skips OP entirely; otherwise OP is left
    // on the edge where the counter still reads 1, so the counter never wraps.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_nextState = (bus.amt != '0) ? OP : DONE;
                end
            end
            OP: begin
                if (r_cnt == W'(1)) begin
                    w_nextState = DONE;
                end
            end
            DONE: begin
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Moore outputs decoded from the state only
    always_comb begin
        w_ready    = 1'b0;
        w_doneTick = 1'b0;
        case (r_state)
            IDLE:    w_ready    = 1'b1;
            DONE:    w_doneTick = 1'b1;
            default: ;
        endcase
    end

    // Datapath: operand and amount are captured only on an accepted start,
    // so later changes to a/amt cannot disturb an operation in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data <= '0;
            r_cnt  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_data <= bus.a;
                        r_cnt  <= bus.amt;
                    end
                end
                OP: begin
                    r_data <= {r_data[N-2:0], r_data[N-1]};
                    r_cnt  <= r_cnt - W'(1);
                end
                default: ;
            endcase
        end
    end

    assign bus.ready     = w_ready;
    assign bus.done_tick = w_doneTick;
    assign bus.y         = r_data;

endmodule

// File: tb/tb_rotate_left_seq.sv
// -----------------------------------------------------------------------------
// tb_rotate_left_seq
//   Self-checking bench for rotate_left_seq. A reference model tracks when the
//   unit is busy and pushes each expected result (value and completion edge)
//   into a queue; a monitor pops and compares on every done_tick.
// -----------------------------------------------------------------------------
module tb_rotate_left_seq;

    localparam int N = 8;
    localparam int W = 3;

    typedef struct {
        logic [N-1:0] y;
        int           doneEdge;
    } exp_t;

    logic clk;
    logic reset;

    rotate_left_seq_if #(.N(N), .W(W)) bus ();

    rotate_left_seq #(.N(N), .W(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int           checkCount;
    int           errorCount;
    int           edgeCount;
    int           modelBusy;
    int           doneCount;
    logic [N-1:0] modelY;
    logic         prevDone;
    exp_t         expQ[$];

    // Free-running clock, 10 ns period
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference rotate-right, written as plain shift arithmetic
    function automatic logic [N-1:0] rotateRight(input logic [N-1:0] v, input int r);
        int x;
        x = int'(v);
        return N'(((x >> r) | (x << (N - r))) & ((1 << N) - 1));
    endfunction

    // Rotate-left by k is rotate-right by (N-k) mod N
    function automatic logic [N-1:0] refRotl(input logic [N-1:0] v, input int k);
        return rotateRight(v, (N - k) % N);
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: an idle unit accepts start, is then busy for amt+1
    // cycles, and the result appears in the cycle after edge (accept + amt).
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            expQ.delete();
            modelBusy = 0;
            modelY    = '0;
        end else begin
            edgeCount++;
            if (modelBusy == 0) begin
                if (bus.start === 1'b1) begin
                    exp_t e;
                    e.y        = refRotl(bus.a, int'(bus.amt));
                    e.doneEdge = edgeCount + int'(bus.amt);
                    expQ.push_back(e);
                    modelY    = e.y;
                    modelBusy = int'(bus.amt) + 1;
                end
            end else begin
                modelBusy--;
            end
        end
    end

    // Monitor: compares outputs against the model away from the active edge
    always @(negedge clk) begin
        if (reset) begin
            checkOutput("resetReady", int'(bus.ready), 1);
            checkOutput("resetDone", int'(bus.done_tick), 0);
            checkOutput("resetY", int'(bus.y), 0);
        end else begin
            checkOutput("ready", int'(bus.ready), (modelBusy == 0) ? 1 : 0);
            if (bus.done_tick === 1'b1) begin
                doneCount++;
                checkOutput("doneWidth", int'(prevDone), 0);
                if (expQ.size() == 0) begin
                    checkCount++;
                    errorCount++;
                    $display("[TB] FAIL unexpectedDone: got done_tick=1, expected none at %0t", $time);
                end else begin
                    exp_t e;
                    e = expQ.pop_front();
                    checkOutput("resultY", int'(bus.y), int'(e.y));
                    checkOutput("doneLatency", edgeCount, e.doneEdge);
                end
            end else begin
                if (expQ.size() > 0 && edgeCount > expQ[0].doneEdge) begin
                    exp_t e;
                    e = expQ.pop_front();
                    checkCount++;
                    errorCount++;
                    $display("[TB] FAIL missedDone: got no done_tick, expected one at edge %0d", e.doneEdge);
                end
                if (modelBusy == 0) begin
                    checkOutput("idleHoldY", int'(bus.y), int'(modelY));
                end
            end
        end
        prevDone = bus.done_tick;
    end

    // Waits (bounded) until the model says the unit is idle again, scrambling
    // a/amt meanwhile to show they are ignored outside the accepting edge.
    task automatic waitIdle();
        int guard;
        guard = 0;
        while (modelBusy != 0 && guard < 20) begin
            @(negedge clk);
            bus.a   = N'($urandom);
            bus.amt = W'($urandom);
            guard++;
        end
        if (modelBusy != 0) begin
            checkCount++;
            errorCount++;
            $display("[TB] FAIL idleTimeout: got busy=%0d, expected 0", modelBusy);
        end
    endtask

    // One start pulse from an idle negedge, then wait for completion
    task automatic applyStimulus(input logic [N-1:0] aVal, input logic [W-1:0] amtVal);
        bus.start = 1'b1;
        bus.a     = aVal;
        bus.amt   = amtVal;
        @(negedge clk);
        bus.start = 1'b0;
        waitIdle();
    endtask

    initial begin
        int snap;
        checkCount = 0;
        errorCount = 0;
        edgeCount  = 0;
        modelBusy  = 0;
        doneCount  = 0;
        modelY     = '0;
        prevDone   = 1'b0;
        reset      = 1'b1;
        bus.start  = 1'b0;
        bus.a      = '0;
        bus.amt    = '0;

        // Reset then idle
        #22 reset = 1'b0;
        repeat (5) begin
            @(negedge clk);
            checkOutput("idleY", int'(bus.y), 0);
            checkOutput("idleReady", int'(bus.ready), 1);
            checkOutput("idleDone", int'(bus.done_tick), 0);
        end

        // Directed amounts
        applyStimulus(8'b10010011, 3'd2);
        checkOutput("dirAmt2", int'(bus.y), 8'b01001110);
        applyStimulus(8'b10010011, 3'd4);
        checkOutput("dirAmt4", int'(bus.y), 8'b00111001);
        applyStimulus(8'b10010011, 3'd6);
        checkOutput("dirAmt6", int'(bus.y), 8'b11100100);
        applyStimulus(8'b10010011, 3'd0);
        checkOutput("dirAmt0", int'(bus.y), 8'b10010011);
        applyStimulus(8'b10010011, 3'd7);
        checkOutput("dirAmt7", int'(bus.y), 8'b11001001);

        // Exhaustive cross-check against rotate-right
        for (int av = 0; av < 256; av++) begin
            for (int k = 0; k < N; k++) begin
                applyStimulus(N'(av), W'(k));
            end
        end

        // start while busy is ignored
        snap      = doneCount;
        bus.start = 1'b1;
        bus.a     = 8'hA5;
        bus.amt   = 3'd5;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 8'hFF;
        bus.amt   = 3'd1;
        @(negedge clk);
        bus.start = 1'b0;
        waitIdle();
        checkOutput("ignoredStartY", int'(bus.y), 8'hB4);
        checkOutput("ignoredStartDones", doneCount - snap, 1);

        // Reset in the middle of an operation
        bus.start = 1'b1;
        bus.a     = 8'h81;
        bus.amt   = 3'd6;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checkOutput("abortY", int'(bus.y), 0);
        checkOutput("abortReady", int'(bus.ready), 1);
        checkOutput("abortDone", int'(bus.done_tick), 0);
        @(negedge clk);
        #2 reset = 1'b0;
        repeat (2) @(negedge clk);
        applyStimulus(8'h81, 3'd1);
        checkOutput("afterAbortY", int'(bus.y), 8'h03);

        // Continuous start: one result every amt+2 cycles
        snap      = doneCount;
        bus.start = 1'b1;
        bus.a     = 8'h01;
        bus.amt   = 3'd3;
        repeat (20) @(negedge clk);
        bus.start = 1'b0;
        waitIdle();
        checkOutput("continuousDones", doneCount - snap, 4);
        checkOutput("continuousY", int'(bus.y), 8'h08);

        // Fully random traffic, including starts while busy
        repeat (400) begin
            bus.start = 1'($urandom_range(0, 1));
            bus.a     = N'($urandom);
            bus.amt   = W'($urandom);
            @(negedge clk);
        end
        bus.start = 1'b0;
        waitIdle();
        repeat (2) @(negedge clk);
        checkOutput("queueDrained", expQ.size(), 0);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
